jelly2_img_from_axi4s: RTL

//  Source end of the img_* stream protocol: converts an AXI4-Stream pixel stream (tuser=SOF, tlast=EOL)

---
 rtl/jelly2_img_from_axi4s.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/jelly2_img_from_axi4s.sv
// AXI4-Stream (tuser=SOF, tlast=EOL) to img_* stream converter.
// Generates row/col flags, de/valid and inserts H/V blanking slots so downstream window buffers can flush.
module jelly2_img_from_axi4s #(
    parameter int DATA_WIDTH  = 8,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int BLANK_WIDTH = 8
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,

    input  logic [X_WIDTH-1:0]     param_width,
    input  logic [Y_WIDTH-1:0]     param_height,
    input  logic [BLANK_WIDTH-1:0] param_hblank,
    input  logic [BLANK_WIDTH-1:0] param_vblank,

    input  logic                   s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic [DATA_WIDTH-1:0]  s_axi4s_tdata,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,

    output logic                   m_img_row_first,
    output logic                   m_img_row_last,
    output logic                   m_img_col_first,
    output logic                   m_img_col_last,
    output logic                   m_img_de,
    output logic [DATA_WIDTH-1:0]  m_img_data,
    output logic                   m_img_valid,

    output logic                   err_sof,
    output logic                   err_eol
);

    // One extra bit so width+hblank and height+vblank never wrap.
    localparam int XC_W = ((X_WIDTH > BLANK_WIDTH) ? X_WIDTH : BLANK_WIDTH) + 1;
    localparam int YC_W = ((Y_WIDTH > BLANK_WIDTH) ? Y_WIDTH : BLANK_WIDTH) + 1;
    localparam logic [XC_W-1:0] X_ONE = 1;
    localparam logic [YC_W-1:0] Y_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t                  state_q, state_d;
    logic [XC_W-1:0]         x_q, x_d;
    logic [YC_W-1:0]         y_q, y_d;
    logic [X_WIDTH-1:0]      w_q;
    logic [Y_WIDTH-1:0]      h_q;
    logic [BLANK_WIDTH-1:0]  hb_q;
    logic [BLANK_WIDTH-1:0]  vb_q;
    logic                    rdy_q;

    logic                    row_first_q, row_first_d;
    logic                    row_last_q,  row_last_d;
    logic                    col_first_q, col_first_d;
    logic                    col_last_q,  col_last_d;
    logic                    de_q,        de_d;
    logic [DATA_WIDTH-1:0]   data_q,      data_d;
    logic                    valid_q,     valid_d;
    logic                    err_sof_q,   err_sof_d;
    logic                    err_eol_q,   err_eol_d;

    logic                    is_idle;
    logic                    acc;
    logic                    sof_start;
    logic                    take_pixel;
    logic                    row_done;
    logic [XC_W-1:0]         w_x, hb_x, row_len;
    logic [YC_W-1:0]         h_y, vb_y;
    logic                    col_first_c, col_last_c, row_end_c;
    logic                    row_first_c, row_last_c, frame_end_c;

    // In IDLE the live parameters describe the frame that the SOF beat opens.
    assign is_idle = (state_q == ST_IDLE);
    assign w_x     = {{(XC_W-X_WIDTH){1'b0}},     (is_idle ? param_width  : w_q)};
    assign hb_x    = {{(XC_W-BLANK_WIDTH){1'b0}}, (is_idle ? param_hblank : hb_q)};
    assign h_y     = {{(YC_W-Y_WIDTH){1'b0}},     (is_idle ? param_height : h_q)};
    assign vb_y    = {{(YC_W-BLANK_WIDTH){1'b0}}, (is_idle ? param_vblank : vb_q)};
    assign row_len = w_x + hb_x;

    assign col_first_c = (x_q == '0);
    assign col_last_c  = (x_q == w_x - X_ONE);
    assign row_end_c   = (x_q == row_len - X_ONE);
    assign row_first_c = (y_q == '0);
    assign row_last_c  = (y_q == h_y - Y_ONE);
    assign frame_end_c = (y_q == h_y + vb_y - Y_ONE);

    assign s_axi4s_tready = cke & rdy_q & (is_idle | (state_q == ST_ACTIVE));
    assign acc            = s_axi4s_tvalid & s_axi4s_tready;
    assign sof_start      = is_idle & acc & s_axi4s_tuser;
    assign take_pixel     = sof_start | ((state_q == ST_ACTIVE) & acc);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        row_done    = 1'b0;
        row_first_d = 1'b0;
        row_last_d  = 1'b0;
        col_first_d = 1'b0;
        col_last_d  = 1'b0;
        de_d        = 1'b0;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_sof_d   = 1'b0;
        err_eol_d   = 1'b0;

        if (take_pixel) begin
            row_first_d = row_first_c;
            row_last_d  = row_last_c;
            col_first_d = col_first_c;
            col_last_d  = col_last_c;
            de_d        = 1'b1;
            valid_d     = 1'b1;
            data_d      = s_axi4s_tdata;
            err_sof_d   = (state_q == ST_ACTIVE) & s_axi4s_tuser;
            err_eol_d   = s_axi4s_tlast & ~col_last_c;
            if (col_last_c) begin
                if (hb_x != '0) begin
                    state_d = ST_HBLANK;
                    x_d     = x_q + X_ONE;
                end else begin
                    row_done = 1'b1;
                end
            end else begin
                state_d = ST_ACTIVE;
                x_d     = x_q + X_ONE;
            end
        end

        case (state_q)
            ST_HBLANK: begin
                row_first_d = row_first_c;
                row_last_d  = row_last_c;
                valid_d     = 1'b1;
                if (row_end_c) begin
                    row_done = 1'b1;
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            ST_VBLANK: begin
                col_first_d = col_first_c;
                col_last_d  = col_last_c;
                valid_d     = 1'b1;
                if (row_end_c) begin
                    x_d = '0;
                    if (frame_end_c) begin
                        state_d = ST_IDLE;
                        y_d     = '0;
                    end else begin
                        y_d = y_q + Y_ONE;
                    end
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            default: ;
        endcase

        // Last slot of an active row (after its hblank, if any).
        if (row_done) begin
            x_d = '0;
            if (row_last_c) begin
                if (vb_y != '0) begin
                    state_d = ST_VBLANK;
                    y_d     = y_q + Y_ONE;
                end else begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                end
            end else begin
                state_d = ST_ACTIVE;
                y_d     = y_q + Y_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            hb_q        <= '0;
            vb_q        <= '0;
            rdy_q       <= 1'b0;
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            col_first_q <= 1'b0;
            col_last_q  <= 1'b0;
            de_q        <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_sof_q   <= 1'b0;
            err_eol_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (cke) begin
                state_q     <= state_d;
                x_q         <= x_d;
                y_q         <= y_d;
                row_first_q <= row_first_d;
                row_last_q  <= row_last_d;
                col_first_q <= col_first_d;
                col_last_q  <= col_last_d;
                de_q        <= de_d;
                data_q      <= data_d;
                valid_q     <= valid_d;
                err_sof_q   <= err_sof_d;
                err_eol_q   <= err_eol_d;
                if (sof_start) begin
                    w_q  <= param_width;
                    h_q  <= param_height;
                    hb_q <= param_hblank;
                    vb_q <= param_vblank;
                end
            end
        end
    end

    assign m_img_row_first = row_first_q;
    assign m_img_row_last  = row_last_q;
    assign m_img_col_first = col_first_q;
    assign m_img_col_last  = col_last_q;
    assign m_img_de        = de_q;
    assign m_img_data      = data_q;
    assign m_img_valid     = valid_q;
    assign err_sof         = err_sof_q;
    assign err_eol         = err_eol_q;

endmodule
